program_fetch_ctrl: RTL

PROGRAM_FETCH_CTRL -- requirements
Module: program_fetch_ctrl

---
 rtl/program_fetch_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/program_fetch_ctrl.sv
// Program fetch controller: issues word reads to program memory, buffers returned
// instructions in a 2-entry FIFO for the decoder, and forwards host loader writes while idle.
module program_fetch_ctrl #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}},
    parameter logic [31:0]       END_WORD  = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              halt,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              instr_valid,
    output logic [31:0]       instr_data,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              instr_ready,
    output logic              pm_re,
    output logic [31:0]       pm_rd_addr,
    input  logic [31:0]       pm_rdata,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [31:0]       host_data,
    output logic              pm_we,
    output logic [31:0]       pm_wr_addr,
    output logic [31:0]       pm_wdata,
    output logic              busy,
    output logic              done,
    output logic              host_err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              last_iss_q, last_iss_d;
    logic              pm_re_q, pm_re_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rvalid_q, rvalid_d;
    logic [ADDR_W-1:0] raddr_q;
    logic [31:0]       fifo_data_q [2];
    logic [ADDR_W-1:0] fifo_addr_q [2];
    logic              wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              pm_we_q, pm_we_d;
    logic [ADDR_W-1:0] pm_wr_addr_q, pm_wr_addr_d;
    logic [31:0]       pm_wdata_q, pm_wdata_d;
    logic              host_err_q, host_err_d;

    logic       pop, push, flush, ret_end, room, can_issue;
    logic [1:0] occ;

    assign pop       = instr_valid && instr_ready;
    assign ret_end   = rvalid_q && (pm_rdata == END_WORD);
    assign room      = (cnt_q != 2'd2) || pop;
    assign occ       = cnt_q - {1'b0, pop};
    assign can_issue = ({1'b0, occ} + {2'b00, pm_re_q}) < 3'd2;

    // A returning word that finds the FIFO full is dropped and re-read later, so
    // the read pipeline can run one ahead of the buffer without losing words.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        last_iss_d   = last_iss_q;
        pm_re_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        rvalid_d     = pm_re_q;
        push         = 1'b0;
        flush        = 1'b0;
        pm_we_d      = 1'b0;
        pm_wr_addr_d = pm_wr_addr_q;
        pm_wdata_d   = pm_wdata_q;
        host_err_d   = 1'b0;

        if (host_we) begin
            if (state_q == IDLE) begin
                pm_we_d      = 1'b1;
                pm_wr_addr_d = host_addr;
                pm_wdata_d   = host_data;
            end else begin
                host_err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                rvalid_d = 1'b0;
                if (start) begin
                    state_d    = RUN;
                    pm_re_d    = 1'b1;
                    rd_addr_d  = start_addr;
                    pc_d       = start_addr + ADDR_W'(1);
                    last_iss_d = (start_addr == LAST_ADDR);
                end
            end
            RUN: begin
                if (halt) begin
                    state_d  = IDLE;
                    flush    = 1'b1;
                    rvalid_d = 1'b0;
                end else if (jump_valid) begin
                    flush      = 1'b1;
                    rvalid_d   = 1'b0;
                    pm_re_d    = 1'b1;
                    rd_addr_d  = jump_addr;
                    pc_d       = jump_addr + ADDR_W'(1);
                    last_iss_d = (jump_addr == LAST_ADDR);
                end else if (ret_end) begin
                    state_d  = DRAIN;
                    rvalid_d = 1'b0;
                end else if (rvalid_q && !room) begin
                    pc_d       = raddr_q;
                    last_iss_d = 1'b0;
                    rvalid_d   = 1'b0;
                end else begin
                    push = rvalid_q;
                    if (rvalid_q && (raddr_q == LAST_ADDR)) begin
                        state_d = DRAIN;
                    end else if (!last_iss_q && can_issue) begin
                        pm_re_d    = 1'b1;
                        rd_addr_d  = pc_q;
                        pc_d       = pc_q + ADDR_W'(1);
                        last_iss_d = (pc_q == LAST_ADDR);
                    end
                end
            end
            DRAIN: begin
                rvalid_d = 1'b0;
                if (halt) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end else if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rvalid_d = 1'b0;
                state_d  = IDLE;
                flush    = halt;
            end
            default: begin
                state_d  = IDLE;
                rvalid_d = 1'b0;
            end
        endcase

        if (flush) begin
            cnt_d  = 2'd0;
            wptr_d = 1'b0;
            rptr_d = 1'b0;
        end else begin
            cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
            wptr_d = wptr_q ^ push;
            rptr_d = rptr_q ^ pop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            last_iss_q   <= 1'b0;
            pm_re_q      <= 1'b0;
            rd_addr_q    <= '0;
            rvalid_q     <= 1'b0;
            wptr_q       <= 1'b0;
            rptr_q       <= 1'b0;
            cnt_q        <= 2'd0;
            pm_we_q      <= 1'b0;
            pm_wr_addr_q <= '0;
            pm_wdata_q   <= '0;
            host_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            last_iss_q   <= last_iss_d;
            pm_re_q      <= pm_re_d;
            rd_addr_q    <= rd_addr_d;
            rvalid_q     <= rvalid_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            pm_we_q      <= pm_we_d;
            pm_wr_addr_q <= pm_wr_addr_d;
            pm_wdata_q   <= pm_wdata_d;
            host_err_q   <= host_err_d;
        end
    end

    always_ff @(posedge clk) begin
        raddr_q <= rd_addr_q;
        if (push) begin
            fifo_data_q[wptr_q] <= pm_rdata;
            fifo_addr_q[wptr_q] <= raddr_q;
        end
    end

    assign instr_valid = (cnt_q != 2'd0);
    assign instr_data  = instr_valid ? fifo_data_q[rptr_q] : 32'd0;
    assign instr_addr  = instr_valid ? fifo_addr_q[rptr_q] : '0;
    assign pm_re       = pm_re_q;
    assign pm_rd_addr  = 32'(rd_addr_q);
    assign pm_we       = pm_we_q;
    assign pm_wr_addr  = 32'(pm_wr_addr_q);
    assign pm_wdata    = pm_wdata_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign host_err    = host_err_q;

endmodule
